node_exp_rescaler: RTL and testbench

- Sits directly downstream of small_buffer_ctrl and consumes its node-product stream (interface_out/output_vld) together with max_exponent/max_exponent_vld.
- Re-biases every FP lane of a node by that node's max exponent so that deep product chains stay inside normal FP range.
- Buffers beats that arrive before the node's exponent is known.
- Emits rescaled beats on a valid/ready stream to the next node stage.

---
 rtl/node_rescale_pkg.sv | 56 +++++
 rtl/node_exp_rescaler_fifo.sv | 49 ++++
 rtl/node_exp_rescaler.sv | 222 ++++++++++++++++++++++
 tb/tb_node_exp_rescaler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_rescale_pkg.sv
// Shared constants, FSM state and per-lane exponent re-bias for node_exp_rescaler.
// FP32 field layout; rescale_lane returns the lane result plus flush/saturate flags.
package node_rescale_pkg;

  localparam int DW       = 32;
  localparam int LANES    = 4;
  localparam int EXP_BIAS = 127;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;

  typedef enum logic {
    WAIT_EXP,
    STREAM
  } state_e;

  typedef struct packed {
    logic [DW-1:0] val;
    logic          flush;
    logic          sat;
  } lane_res_t;

  function automatic lane_res_t rescale_lane(
    input logic [DW-1:0] lane,
    input logic [7:0]    mx,
    input logic [9:0]    bias
  );
    lane_res_t  r;
    logic       s;
    logic [7:0] e;
    logic [9:0] en;
    s       = lane[SIGN_BIT];
    e       = lane[EXP_MSB:EXP_LSB];
    en      = {2'b00, e} - {2'b00, mx} + bias;
    r.val   = lane;
    r.flush = 1'b0;
    r.sat   = 1'b0;
    // en is a 10-bit two's-complement value; bit 9 marks e' < 0
    if (e == 8'd0) begin
      r.val = {s, {(DW-1){1'b0}}};
    end else if (e == 8'hFF) begin
      r.val = lane;
    end else if (en[9] || en == 10'd0) begin
      r.val   = {s, {(DW-1){1'b0}}};
      r.flush = 1'b1;
    end else if (en >= 10'd255) begin
      r.val = {s, 8'hFF, {MAN_W{1'b0}}};
      r.sat = 1'b1;
    end else begin
      r.val = {s, en[7:0], lane[MAN_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/node_exp_rescaler_fifo.sv
// sync_fifo: beat buffer for node_exp_rescaler.
// Extra pointer MSB separates full from empty; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full) wr_d = wr_q + (AW+1)'(1);
    if (pop && !empty) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/node_exp_rescaler.sv
// node_exp_rescaler: re-biases every FP lane of a node by its max exponent.
// Define RESCALE_STATS_EN to add flush_cnt / sat_cnt lane counters.
module node_exp_rescaler #(
  parameter int DW         = 32,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int EXP_BIAS   = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           num_of_line_per_node_minusone,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic                  in_vld,
  output logic                  in_ready,
  input  logic [7:0]            max_exponent,
  input  logic                  max_exponent_vld,
  output logic [LANES*DW-1:0]   out_data,
  output logic                  out_vld,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [7:0]            out_scale,
  output logic                  exp_overrun
`ifdef RESCALE_STATS_EN
  ,
  output logic [15:0]           flush_cnt,
  output logic [15:0]           sat_cnt
`endif
);

  import node_rescale_pkg::*;

  localparam int         BW     = LANES * DW;
  localparam logic [9:0] BIAS10 = 10'(EXP_BIAS);

  state_e        state_q, state_d;
  logic          act_vld_q, act_vld_d;
  logic [7:0]    act_q, act_d;
  logic          pend_vld_q, pend_vld_d;
  logic [7:0]    pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic [10:0]   node_len_q, node_len_d;
  logic [10:0]   beat_cnt_q, beat_cnt_d;
  logic [BW-1:0] out_data_q, out_data_d;
  logic [7:0]    out_scale_q, out_scale_d;
  logic          out_last_q, out_last_d;
  logic          out_vld_q, out_vld_d;

  logic          push, pop, full, empty, last_pop;
  logic [BW-1:0] fifo_rdata, res_data;
  logic [LANES-1:0] res_flush, res_sat;

  assign in_ready = !rst && !full;
  assign push     = in_vld && in_ready;

  sync_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  assign pop      = (state_q == STREAM) && !empty &&
                    (!out_vld_q || out_ready);
  assign last_pop = pop && (beat_cnt_q == node_len_q);

  always_comb begin : lane_math
    lane_res_t r;
    r         = '0;
    res_data  = '0;
    res_flush = '0;
    res_sat   = '0;
    for (int i = 0; i < LANES; i++) begin
      r = rescale_lane(fifo_rdata[i*DW +: DW], act_q, BIAS10);
      res_data[i*DW +: DW] = r.val;
      res_flush[i]         = r.flush;
      res_sat[i]           = r.sat;
    end
  end

  // Retire first so a same-cycle strobe can land in a freed slot
  always_comb begin
    act_vld_d  = act_vld_q;
    act_d      = act_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    ovr_d      = ovr_q;
    if (last_pop) begin
      act_vld_d  = pend_vld_q;
      act_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    if (max_exponent_vld) begin
      if (!act_vld_d) begin
        act_vld_d = 1'b1;
        act_d     = max_exponent;
      end else if (!pend_vld_d) begin
        pend_vld_d = 1'b1;
        pend_d     = max_exponent;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    node_len_d = node_len_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      WAIT_EXP: begin
        if (act_vld_q) begin
          node_len_d = num_of_line_per_node_minusone;
          beat_cnt_d = '0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (pop) beat_cnt_d = beat_cnt_q + 11'd1;
        if (last_pop) begin
          if (pend_vld_q) begin
            node_len_d = num_of_line_per_node_minusone;
            beat_cnt_d = '0;
          end else begin
            state_d = WAIT_EXP;
          end
        end
      end
      default: state_d = WAIT_EXP;
    endcase
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_scale_d = out_scale_q;
    out_last_d  = out_last_q;
    if (pop) begin
      out_vld_d   = 1'b1;
      out_data_d  = res_data;
      out_scale_d = act_q;
      out_last_d  = last_pop;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_EXP;
      act_vld_q   <= 1'b0;
      act_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      ovr_q       <= 1'b0;
      node_len_q  <= '0;
      beat_cnt_q  <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_scale_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_vld_q   <= act_vld_d;
      act_q       <= act_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      node_len_q  <= node_len_d;
      beat_cnt_q  <= beat_cnt_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_scale_q <= out_scale_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_scale   = out_scale_q;
  assign out_last    = out_last_q;
  assign exp_overrun = ovr_q;

`ifdef RESCALE_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    sat_cnt_d   = sat_cnt_q;
    if (pop) begin
      for (int i = 0; i < LANES; i++) begin
        flush_cnt_d = flush_cnt_d + 16'(res_flush[i]);
        sat_cnt_d   = sat_cnt_d + 16'(res_sat[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
      sat_cnt_q   <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign sat_cnt   = sat_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{res_flush, res_sat};
`endif

endmodule

// File: tb/tb_node_exp_rescaler.sv
// Self-checking bench for node_exp_rescaler: table vectors, directed
// corner sequences and random beats against a queue-based reference model.
module tb_node_exp_rescaler;

  localparam int DW = 32;
  localparam int LANES = 4;
  localparam int BW = DW * LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   nlen = '0;
  logic [BW-1:0] in_data = '0;
  logic          in_vld = 1'b0;
  logic          in_ready;
  logic [7:0]    max_exponent = '0;
  logic          max_exponent_vld = 1'b0;
  logic [BW-1:0] out_data;
  logic          out_vld;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [7:0]    out_scale;
  logic          exp_overrun;
`ifdef RESCALE_STATS_EN
  logic [15:0]   flush_cnt, sat_cnt;
`endif

  node_exp_rescaler dut (
    .clk                           (clk),
    .rst                           (rst),
    .num_of_line_per_node_minusone (nlen),
    .in_data                       (in_data),
    .in_vld                        (in_vld),
    .in_ready                      (in_ready),
    .max_exponent                  (max_exponent),
    .max_exponent_vld              (max_exponent_vld),
    .out_data                      (out_data),
    .out_vld                       (out_vld),
    .out_ready                     (out_ready),
    .out_last                      (out_last),
    .out_scale                     (out_scale),
    .exp_overrun                   (exp_overrun)
`ifdef RESCALE_STATS_EN
    ,
    .flush_cnt                     (flush_cnt),
    .sat_cnt                       (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [BW-1:0] in_q[$];
  int            scale_q[$];
  int            pos = 0;
  bit            ovr_exp = 1'b0;
  int            out_cnt = 0;
  bit            toggle_en = 1'b0;

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_lane(logic [31:0] x, int mx);
    int e, en;
    e = int'(x[30:23]);
    if (e == 0) return {x[31], 31'd0};
    if (e == 255) return x;
    en = e - mx + 127;
    if (en <= 0) return {x[31], 31'd0};
    if (en >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], 8'(en), x[22:0]};
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] b;
    for (int l = 0; l < LANES; l++) b[l*DW +: DW] = $urandom;
    return b;
  endfunction

  // monitor: records accepted beats, checks each output handshake
  logic [BW-1:0] prev_data;
  logic [7:0]    prev_scale;
  logic          prev_last;
  bit            prev_stall = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_vld", out_vld, 1'b1);
          chk("hold_beat", {out_last, out_scale, out_data},
              {prev_last, prev_scale, prev_data});
        end
        if (in_vld && in_ready) in_q.push_back(in_data);
        if (out_vld && out_ready) begin
          if (in_q.size() == 0 || scale_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0h required=no_beat", out_data);
          end else begin
            logic [BW-1:0] exp_d;
            bit            exp_last;
            for (int l = 0; l < LANES; l++)
              exp_d[l*DW +: DW] = ref_lane(in_q[0][l*DW +: DW], scale_q[0]);
            exp_last = (pos == int'(nlen));
            chk("out_beat", {out_last, out_scale, out_data},
                {exp_last, 8'(scale_q[0]), exp_d});
            void'(in_q.pop_front());
            out_cnt++;
            if (exp_last) begin
              pos = 0;
              void'(scale_q.pop_front());
            end else begin
              pos++;
            end
          end
        end
        prev_stall = out_vld && !out_ready;
        prev_data  = out_data;
        prev_scale = out_scale;
        prev_last  = out_last;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_vld = 1'b0;
    max_exponent_vld = 1'b0;
    out_ready = 1'b1;
    tick(2);
    chk("rst_outputs", {out_vld, out_last, out_scale, exp_overrun, out_data},
        '0);
    chk("rst_in_ready", in_ready, 1'b0);
    in_q.delete();
    scale_q.delete();
    pos = 0;
    ovr_exp = 1'b0;
    out_cnt = 0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
  endtask

  task automatic strobe(input int mx);
    if (scale_q.size() >= 2) ovr_exp = 1'b1;
    else scale_q.push_back(mx);
    max_exponent = 8'(mx);
    max_exponent_vld = 1'b1;
    tick(1);
    max_exponent_vld = 1'b0;
  endtask

  task automatic push(input logic [BW-1:0] d);
    int n;
    n = 0;
    in_data = d;
    in_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL push_timeout actual=not_ready required=ready");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((in_q.size() != 0 || out_vld) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("drain_done", in_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] lane;
    int          mx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h3F800000, 130, 32'h3E000000};
    vecs[1]  = '{32'h7D000000, 10,  32'h7F800000};
    vecs[2]  = '{32'h01000000, 200, 32'h00000000};
    vecs[3]  = '{32'hFFC00000, 50,  32'hFFC00000};
    vecs[4]  = '{32'h80000001, 20,  32'h80000000};
    vecs[5]  = '{32'hC0000000, 127, 32'hC0000000};
    vecs[6]  = '{32'h3F800000, 0,   32'h7F000000};
    vecs[7]  = '{32'h3F800000, 255, 32'h00000000};
    vecs[8]  = '{32'h00800000, 127, 32'h00800000};
    vecs[9]  = '{32'h40000000, 0,   32'h7F800000};
    vecs[10] = '{32'hBF800000, 1,   32'hFE800000};
    vecs[11] = '{32'h7F800000, 200, 32'h7F800000};

    // reset state, then directed 4-beat node with known latency
    do_reset();
    nlen = 11'd3;
    strobe(130);
    tick(3);
    push({4{32'h3F800000}});
    chk("lat_accept_cycle", out_vld, 1'b0);
    push({4{32'h3F800000}});
    chk("lat_two_cycles", out_vld, 1'b1);
    chk("lat_first_data", out_data, {4{32'h3E000000}});
    push({4{32'h3F800000}});
    push({4{32'h3F800000}});
    drain();
    chk("node1_count", out_cnt, 4);

    // beats arrive before exponent
    for (int b = 0; b < 4; b++) begin
      logic [BW-1:0] d;
      d = rnd_beat();
      d[31:0] = 32'h3F800000;
      push(d);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("stall_no_vld", out_vld, 1'b0);
    end
    strobe(127);
    drain();
    chk("node2_count", out_cnt, 8);

    // table-driven single-beat nodes
    nlen = 11'd0;
    for (int v = 0; v < 12; v++) begin
      strobe(vecs[v].mx);
      tick(2);
      push({4{vecs[v].lane}});
      tick(1);
      chk("vec_data", out_data, {4{vecs[v].exp}});
      chk("vec_scale_last", {out_vld, out_last, out_scale},
          {2'b11, 8'(vecs[v].mx)});
      tick(1);
    end

    // backpressure: fill FIFO with no scale, then drain with toggling ready
    do_reset();
    nlen = 11'd19;
    for (int b = 0; b < 16; b++) push(rnd_beat());
    chk("full_ready", in_ready, 1'b0);
    toggle_en = 1'b1;
    fork
      begin
        while (toggle_en) begin
          tick(1);
          out_ready = ~out_ready;
        end
      end
    join_none
    strobe($urandom_range(100, 150));
    for (int b = 0; b < 4; b++) push(rnd_beat());
    drain();
    toggle_en = 1'b0;
    tick(3);
    out_ready = 1'b1;
    chk("bp_count", out_cnt, 20);

    // scale queueing and overrun
    do_reset();
    nlen = 11'd1;
    strobe(130);
    strobe(128);
    strobe(126);
    tick(1);
    chk("overrun_set", exp_overrun, ovr_exp);
    for (int b = 0; b < 4; b++) push(rnd_beat());
    drain();
    tick(5);
    chk("overrun_sticky", exp_overrun, ovr_exp);
    chk("scales_used", scale_q.size(), 0);

    // reset mid-node
    do_reset();
    nlen = 11'd3;
    strobe(140);
    tick(2);
    push(rnd_beat());
    push(rnd_beat());
    do_reset();
    nlen = 11'd3;
    strobe(120);
    tick(2);
    for (int b = 0; b < 4; b++) push(rnd_beat());
    drain();
    chk("after_rst_count", out_cnt, 4);

    // random nodes
    do_reset();
    for (int k = 0; k < 6; k++) begin
      int nb;
      nb = $urandom_range(0, 3);
      nlen = 11'(nb);
      strobe($urandom_range(0, 255));
      tick(2);
      for (int b = 0; b <= nb; b++) push(rnd_beat());
      drain();
      tick(2);
    end
    chk("rand_scales_used", scale_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
